// File: rtl/io_pulldown_debounce.sv
// Purpose : scans WIDTH pins with a shared drive-low / release / sample cycle and debounces each pin.
// Latency : out/rise/fall/sample_valid update on the edge that ends the SAMPLE cycle (1 cycle after SAMPLE).
// Backpressure: none; a free-running scan with no flow control.
//
// Ports:
//   clk          design clock, rising edge
//   n_rst        asynchronous active-low reset (pins are driven low while asserted)
//   io           WIDTH pins; driven 0 in DRIVE, high-Z in SETTLE and SAMPLE
//   out          debounced level per channel (registered)
//   rise / fall  one-cycle pulse per channel when out goes 0->1 / 1->0
//   sample_valid one-cycle pulse after every SAMPLE cycle
//
// Build option: define IO_PULLDOWN_EDGE_EN to build the rise/fall registers.
// When it is undefined, rise and fall are tied to 0.
module io_pulldown_debounce #(
    parameter int WIDTH          = 5,
    parameter int DRIVE_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 16,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    inout  wire  [WIDTH-1:0] io,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             sample_valid
);

    localparam int CNT_MAX = (DRIVE_CYCLES > SETTLE_CYCLES) ? DRIVE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    // One-bit minimum so STABLE_SAMPLES == 1 still elaborates a legal counter.
    localparam int SW      = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;

    localparam logic [CW-1:0] DRIVE_LAST  = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LAST   = SW'(STABLE_SAMPLES - 1);

    generate
        if (DRIVE_CYCLES < 1 || SETTLE_CYCLES < 1 || STABLE_SAMPLES < 1) begin : g_bad_param
            $error("io_pulldown_debounce: DRIVE_CYCLES, SETTLE_CYCLES and STABLE_SAMPLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_DRIVE  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             w_drive;
    logic             w_sample;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [SW-1:0]    r_stab     [WIDTH];
    logic [SW-1:0]    w_stab_nxt [WIDTH];
    logic             r_sample_valid;

    // ---------------------------------------------------------------- scan FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DRIVE:  if (r_cnt == DRIVE_LAST)  w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: w_state_nxt = ST_DRIVE;
            default:   w_state_nxt = ST_DRIVE;
        endcase
    end

    // Cycle counter restarts on every state change, so each state's count starts at 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_DRIVE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
        end
    end

    // The reset value of r_state is DRIVE, so the pins are pulled low during reset as well.
    assign w_drive  = (r_state == ST_DRIVE);
    assign w_sample = (r_state == ST_SAMPLE);

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_pin
            assign io[g] = w_drive ? 1'b0 : 1'bz;
        end
    endgenerate

    // ---------------------------------------------------------------- debounce
    // A sample that matches out clears the counter. The counter tops out at
    // STABLE_SAMPLES-1; the next differing sample flips out instead of counting.
    always_comb begin
        w_out_nxt = r_out;
        for (int i = 0; i < WIDTH; i++) begin
            w_stab_nxt[i] = r_stab[i];
            if (w_sample) begin
                if (io[i] == r_out[i]) begin
                    w_stab_nxt[i] = '0;
                end else if (r_stab[i] == STAB_LAST) begin
                    w_out_nxt[i]  = ~r_out[i];
                    w_stab_nxt[i] = '0;
                end else begin
                    w_stab_nxt[i] = r_stab[i] + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_out          <= '0;
            r_sample_valid <= 1'b0;
            for (int i = 0; i < WIDTH; i++) r_stab[i] <= '0;
        end else begin
            r_out          <= w_out_nxt;
            r_sample_valid <= w_sample;
            for (int i = 0; i < WIDTH; i++) r_stab[i] <= w_stab_nxt[i];
        end
    end

    assign out          = r_out;
    assign sample_valid = r_sample_valid;

`ifdef IO_PULLDOWN_EDGE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_out_nxt & ~r_out;
            r_fall <= ~w_out_nxt & r_out;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: doc/io_pulldown_debounce.md
IO_PULLDOWN_DEBOUNCE -- requirements
Module: io_pulldown_debounce

Interface
REQ-001 Parameter WIDTH, default 5: number of independent inout channels.
REQ-002 Parameter DRIVE_CYCLES, default 16: cycles each pin is actively driven low per scan.
REQ-003 Parameter SETTLE_CYCLES, default 16: cycles each pin is released before sampling.
REQ-004 Parameter STABLE_SAMPLES, default 4: consecutive differing samples required to flip an output.
REQ-005 clk  input  1  single design clock, rising edge.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 io  inout  WIDTH  external pins (buttons / DIP switches), active-high when pressed/on.
REQ-008 out  output  WIDTH  debounced, registered level per channel.
REQ-009 rise  output  WIDTH  one-cycle pulse per channel on out 0->1.
REQ-010 fall  output  WIDTH  one-cycle pulse per channel on out 1->0.
REQ-011 sample_valid  output  1  one-cycle pulse each time a scan sample is applied.

Function
REQ-012 Scan FSM states DRIVE -> SETTLE -> SAMPLE -> DRIVE, shared by all channels.
REQ-013 DRIVE lasts exactly DRIVE_CYCLES cycles; all io bits driven 0.
REQ-014 SETTLE lasts exactly SETTLE_CYCLES cycles; all io bits high-Z.
REQ-015 SAMPLE lasts exactly 1 cycle; io high-Z; io captured into the debounce logic at that edge.
REQ-016 Scan period SHALL be DRIVE_CYCLES+SETTLE_CYCLES+1 cycles (33 at defaults).
REQ-017 Cycle counter width $clog2(max(DRIVE_CYCLES,SETTLE_CYCLES))+1; counter clears on every state change.
REQ-018 Per channel i: sample == out[i] -> stability counter cleared to 0.
REQ-019 Per channel i: sample != out[i] and counter < STABLE_SAMPLES-1 -> counter increments.
REQ-020 Per channel i: sample != out[i] and counter == STABLE_SAMPLES-1 -> out[i] inverts, counter cleared.
REQ-021 STABLE_SAMPLES == 1 -> out[i] follows each sample with no filtering.
REQ-022 out, rise, fall, sample_valid update on the edge ending the SAMPLE cycle (latency 1 cycle from SAMPLE).
REQ-023 rise[i]/fall[i] high for exactly the one cycle after out[i] changes; never both high.
REQ-024 sample_valid high for exactly the one cycle following every SAMPLE state.
REQ-025 Channels SHALL be fully independent; simultaneous flips on several channels allowed in one update.
REQ-026 Stability counters saturate by construction: never exceed STABLE_SAMPLES-1.
REQ-027 Parameters DRIVE_CYCLES, SETTLE_CYCLES, STABLE_SAMPLES SHALL be >= 1; elaboration error otherwise.

Reset
REQ-028 n_rst low SHALL immediately force: state DRIVE, cycle counter 0, all stability counters 0.
REQ-029 n_rst low SHALL immediately force out, rise, fall = 0 and sample_valid = 0.
REQ-030 During reset io SHALL be driven 0 (DRIVE-state behaviour).
REQ-031 Reset asserted mid-scan discards partial counts; first DRIVE after release is full length.

Configuration
REQ-032 Macro IO_PULLDOWN_EDGE_EN defined: rise/fall generated per REQ-009, REQ-010, REQ-023.
REQ-033 Macro IO_PULLDOWN_EDGE_EN undefined: no edge registers built; rise and fall tied to constant 0.

Verification
REQ-034 Defaults, io[0] held 1 from reset release (cycle 0) -> first SAMPLE at cycle 32, out[0]=1 at cycle 132 (4th sample), rise[0]=1 at cycle 132 only.
REQ-035 io[0] samples 1,1,0,1,1,1,1 -> out[0] stays 0 through sample 6, rises after sample 7; no intermediate rise pulse.
REQ-036 io[4:0]=5'b10101 held, then 5'b00000 after out settles -> fall[4],fall[2],fall[0] pulse together 4 samples later.
REQ-037 Pin-drive check: io sampled by bench shows 0 driven on cycles 0-15, Z on 16-32, repeating every 33 cycles.
REQ-038 n_rst asserted during SETTLE with out=5'b00001 -> out=0, rise/fall/sample_valid=0 immediately; next sample_valid at cycle 33 after release.
REQ-039 Build without IO_PULLDOWN_EDGE_EN, repeat REQ-034 -> out[0] identical, rise and fall remain 0 throughout.
